alu_bist_ctrl: RTL and testbench
================================

Name: alu_bist_ctrl

Overview:
Hardware stimulus-and-check engine that acts as the initiator for the 4-bit ALU (lab1_4 interface: a, b, c, aluctr in; d, e out).
- On start, sweeps all 2048 input vectors, drives them into the ALU under test, and compares d/e against an internal golden model.
- Reports pass/fail, an error count, and the first failing vector.
- Sits beside the ALU on the board; results go to LEDs/7-seg.

Parameters:
- WIDTH, 4, operand width of a/b/d (sweep length is 2^(2*WIDTH+3)).
- SETTLE_CYCLES, 1, cycles waited after driving a vector before sampling d/e (range 1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a sweep when idle or done.
- a  output  WIDTH  operand A to ALU.
- b  output  WIDTH  operand B to ALU.
- c  output  1  carry-in to ALU.
- aluctr  output  2  opcode to ALU.
- d  input  WIDTH  ALU result.
- e  input  1  ALU carry-out.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start.
- pass  output  1  valid when done; 1 = zero mismatches.
- err_cnt  output  8  mismatch count, saturating at 255.
- fail_vec  output  2*WIDTH+3  first failing {c, aluctr, a, b}.
- fail_de  output  WIDTH+1  {e,d} observed at first failure.

Behaviour:
- Reset, asynchronous on rst_n low:
  - FSM goes to IDLE.
  - a, b, c, aluctr, busy, done, err_cnt, fail_vec and fail_de are all 0.
  - pass = 0.
- Vector index idx = {c, aluctr, a, b}, 2*WIDTH+3 bits:
  - b is the LSB (fastest-changing); c is the MSB.
  - Outputs a/b/c/aluctr are registered slices of idx.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE: on start, go to DRIVE. Clear idx, err_cnt, fail_vec, fail_de and the first-fail flag. Set busy = 1.
  - DRIVE: idx is on the outputs. Load settle counter = SETTLE_CYCLES-1. Go to SETTLE.
  - SETTLE: decrement the counter; go to CHECK when it reaches 0.
  - CHECK: sample d/e and compare against golden. If idx is all ones, go to DONE; otherwise increment idx and go to DRIVE.
  - Per-vector cost is SETTLE_CYCLES+2 cycles. Total sweep is 2048*(SETTLE_CYCLES+2) cycles from the first DRIVE.
  - DONE: busy = 0, done = 1, pass = (err_cnt == 0). Outputs keep the last vector. On start, re-enter the IDLE start action in the same edge (restart).
- Golden model, all arithmetic in WIDTH+1 bits:
  - aluctr 00: {e,d} = a + b + c.
  - aluctr 01: d = a & b, e = 0.
  - aluctr 10: d = a | b, e = 0.
  - aluctr 11: d = a ^ b, e = 0.
- Mismatch: any bit of {e,d} differs from golden. An X/Z on d or e counts as a mismatch in simulation.
- On a mismatch:
  - err_cnt increments, saturating at 255 (no wrap).
  - If the first-fail flag is clear, capture fail_vec = idx and fail_de = {e,d}, then set the flag.
- Boundary conditions:
  - start while busy is ignored.
  - idx wrap at all ones ends the sweep; it never wraps back to 0 while busy.
  - rst_n low mid-sweep aborts immediately to the reset values.
  - start in the same cycle as CHECK of the last vector is ignored; the FSM still goes to DONE.

Optional Feature:
- Macro ALU_BIST_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes straight to DONE with err_cnt = 1 and pass = 0. Outputs hold the failing vector.
- Undefined: the full sweep always completes and all mismatches are counted.

Decomposition:
- Package alu_bist_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_XOR=2'b11;
  - the state encoding constants;
  - the err_cnt saturation value 255.
- One natural sub-module: alu_golden, a combinational reference ALU producing the expected {e,d}.
  - Instantiated once inside alu_bist_ctrl.

Test Plan:
- Correct behavioural ALU, SETTLE_CYCLES=1, one start pulse:
  - busy for 6144 cycles, then done = 1, pass = 1, err_cnt = 0, fail_vec = 0.
- ALU with d[0] stuck-at-0:
  - done with pass = 0, err_cnt = 255 (saturated).
  - fail_vec = 11'h001 (a=0, b=1, add, c=0), fail_de = 5'b00000.
- ALU faulty only for XOR with a=4'hF, b=4'hF (returns d=4'h1):
  - err_cnt = 2, fail_vec = 11'h3FF, fail_de = 5'h01.
- rst_n pulsed low at cycle 1000 of a sweep:
  - outputs go to 0 immediately, busy = 0.
  - A new start then completes a full 6144-cycle sweep.
- start pulses during the sweep (cycles 10 and 3000):
  - no effect; sweep length is unchanged.
  - start after done restarts and clears err_cnt.
- ALU_BIST_STOP_ON_ERR_EN defined, stuck-at-0 ALU:
  - done at the second vector's CHECK, err_cnt = 1, a/b/c/aluctr hold idx 11'h001.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared constants for the ALU BIST controller: opcodes, FSM state encoding
// and the error-counter saturation value.
package alu_bist_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [7:0] ERR_SAT = 8'd255;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StDrive  = 3'd1,
        StSettle = 3'd2,
        StCheck  = 3'd3,
        StDone   = 3'd4
    } state_t;

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU: expected {e,d} for a given {c, aluctr, a, b}.
module alu_golden
    import alu_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic [1:0]       aluctr,
    output logic [WIDTH:0]   expected
);

    // Reference result; logic ops never produce a carry-out.
    always_comb begin
        expected = '0;
        unique case (aluctr)
            OP_ADD: expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
            OP_AND: expected = {1'b0, a & b};
            OP_OR:  expected = {1'b0, a | b};
            OP_XOR: expected = {1'b0, a ^ b};
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST engine for the 4-bit ALU: sweeps every {c, aluctr, a, b} vector,
// compares d/e with alu_golden and reports pass, error count and first failure.
// Optional build macro ALU_BIST_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 c,
    output logic [1:0]           aluctr,
    input  logic [WIDTH-1:0]     d,
    input  logic                 e,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_cnt,
    output logic [2*WIDTH+2:0]   fail_vec,
    output logic [WIDTH:0]       fail_de
);

    localparam int unsigned IW          = 2 * WIDTH + 3;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [3:0]      settle_cnt;
    logic            first_fail;
    logic [WIDTH:0]  expected;
    logic            mismatch;
    logic            sweep_end;

    // The ALU ports are direct slices of the registered vector index.
    assign {c, aluctr, a, b} = idx;

    alu_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a        (a),
        .b        (b),
        .c        (c),
        .aluctr   (aluctr),
        .expected (expected)
    );

    // Case inequality so an X/Z from the ALU is flagged rather than masked.
    assign mismatch = ({e, d} !== expected);

`ifdef ALU_BIST_STOP_ON_ERR_EN
    assign sweep_end = mismatch || (&idx);
`else
    assign sweep_end = &idx;
`endif

    // Sweep FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            idx        <= '0;
            settle_cnt <= '0;
            first_fail <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_de    <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state      <= StDrive;
                        idx        <= '0;
                        err_cnt    <= '0;
                        fail_vec   <= '0;
                        fail_de    <= '0;
                        first_fail <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                StDrive: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= StSettle;
                end
                StSettle: begin
                    if (settle_cnt == 4'd0) begin
                        state <= StCheck;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        if (err_cnt != ERR_SAT) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        if (!first_fail) begin
                            fail_vec   <= idx;
                            fail_de    <= {e, d};
                            first_fail <= 1'b1;
                        end
                    end
                    if (sweep_end) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // err_cnt still holds the pre-check count here.
                        pass  <= (err_cnt == 8'd0) && !mismatch;
                    end else begin
                        idx   <= idx + IW'(1);
                        state <= StDrive;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl: a behavioural ALU with selectable
// faults sits beside the DUT; results are checked against a table of known
// outcomes and against a sweep-level model for randomly injected faults.
module tb_alu_bist_ctrl;

    localparam int NV  = 2048;
    localparam int PER = 3;  // SETTLE_CYCLES + 2

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  a, b, d;
    logic        c, e;
    logic [1:0]  aluctr;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [10:0] fail_vec;
    logic [4:0]  fail_de;

    int          n_checks = 0;
    int          n_fail = 0;
    int          fault_mode = 0;
    logic [4:0]  flip [NV];

    typedef struct {
        int mode;
        int exp_cycles;
        int exp_pass;
        int exp_err;
        int exp_vec;
        int exp_de;
        int exp_hold;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    alu_bist_ctrl #(
        .WIDTH         (4),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c        (c),
        .aluctr   (aluctr),
        .d        (d),
        .e        (e),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec),
        .fail_de  (fail_de)
    );

    // Reference ALU result for vector v = {c, op, a, b}.
    function automatic int golden_de(int v);
        int vb = v & 15;
        int va = (v >> 4) & 15;
        int op = (v >> 8) & 3;
        int vc = (v >> 10) & 1;
        case (op)
            0:       return va + vb + vc;
            1:       return va & vb;
            2:       return va | vb;
            default: return va ^ vb;
        endcase
    endfunction

    // ALU under test with the selected fault.
    function automatic int faulty_de(int mode, int v);
        int g = golden_de(v);
        case (mode)
            1:       return g & 'h1E;
            2:       return (v == 'h3FF || v == 'h7FF) ? 1 : g;
            3:       return g ^ int'(flip[v]);
            default: return g;
        endcase
    endfunction

    always_comb begin
        int v;
        int r;
        v = int'({c, aluctr, a, b});
        r = faulty_de(fault_mode, v);
        {e, d} = 5'(r);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".abc"}, int'({c, aluctr, a, b}), 0);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 0);
        check({tag, ".pass"}, int'(pass), 0);
        check({tag, ".err_cnt"}, int'(err_cnt), 0);
        check({tag, ".fail_vec"}, int'(fail_vec), 0);
        check({tag, ".fail_de"}, int'(fail_de), 0);
    endtask

    // Whole-sweep model: walk every vector in order and tally the outcome.
    task automatic model(input int mode, output vec_t r);
        int first = -1;
        int last = NV - 1;
        r.mode = mode;
        r.exp_err = 0;
        r.exp_de = 0;
        for (int v = 0; v < NV; v++) begin
            if (faulty_de(mode, v) != golden_de(v)) begin
                if (r.exp_err < 255) r.exp_err++;
                if (first < 0) begin
                    first = v;
                    r.exp_de = faulty_de(mode, v);
                end
`ifdef ALU_BIST_STOP_ON_ERR_EN
                last = v;
                break;
`endif
            end
        end
        r.exp_vec = (first < 0) ? 0 : first;
        r.exp_pass = (r.exp_err == 0) ? 1 : 0;
        r.exp_cycles = (last + 1) * PER;
        r.exp_hold = last;
    endtask

    task automatic run_and_check(input vec_t t, input bit poke_mid, input bit poke_last,
                                 input string tag);
        int cycles = 0;
        fault_mode = t.mode;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, ".busy_on_start"}, int'(busy), 1);
        check({tag, ".err_cleared"}, int'(err_cnt), 0);
        while (busy === 1'b1 && cycles < 8000) begin
            cycles++;
            start = (poke_mid && (cycles == 10 || cycles == 3000)) ||
                    (poke_last && cycles == t.exp_cycles);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".cycles"}, cycles, t.exp_cycles);
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".pass"}, int'(pass), t.exp_pass);
        check({tag, ".err_cnt"}, int'(err_cnt), t.exp_err);
        check({tag, ".fail_vec"}, int'(fail_vec), t.exp_vec);
        check({tag, ".fail_de"}, int'(fail_de), t.exp_de);
        check({tag, ".hold_vec"}, int'({c, aluctr, a, b}), t.exp_hold);
        if (poke_last) begin
            @(negedge clk);
            check({tag, ".done_kept"}, int'(done), 1);
            check({tag, ".busy_kept"}, int'(busy), 0);
        end
    endtask

    initial begin
        vec_t r;
        for (int v = 0; v < NV; v++) flip[v] = '0;

        tbl[0] = '{0, 6144, 1, 0, 0, 0, 'h7FF};
`ifdef ALU_BIST_STOP_ON_ERR_EN
        tbl[1] = '{1, 6, 0, 1, 'h001, 0, 'h001};
        tbl[2] = '{2, 3072, 0, 1, 'h3FF, 'h01, 'h3FF};
`else
        tbl[1] = '{1, 6144, 0, 255, 'h001, 0, 'h7FF};
        tbl[2] = '{2, 6144, 0, 2, 'h3FF, 'h01, 'h7FF};
`endif
        tbl[3] = '{0, 6144, 1, 0, 0, 0, 'h7FF};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Fixed fault scenarios; each after the first restarts from DONE.
        for (int i = 0; i < 4; i++) begin
            run_and_check(tbl[i], i == 0, i == 3, $sformatf("tbl%0d", i));
        end

        // Random single-bit/multi-bit flips at several densities.
        for (int k = 0; k < 3; k++) begin
            int den;
            den = (k == 0) ? 16 : (k == 1) ? 300 : 1500;
            for (int v = 0; v < NV; v++) begin
                flip[v] = ($urandom_range(den - 1, 0) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
            end
            model(3, r);
            run_and_check(r, 1'b0, 1'b0, $sformatf("rnd%0d", k));
        end

        // Reset in the middle of a sweep, then a clean full sweep.
        fault_mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (999) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk) rst_n = 1'b1;
        run_and_check(tbl[0], 1'b0, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
